decryption_block: RTL and testbench
===================================

DECRYPTION_BLOCK -- requirements
Module: decryption_block

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, the AES-128 round count; only 10 is supported.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port decryptEnable, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port key, input, 128 bits: forward AES-128 cipher key, the same key the encryption block uses.
REQ-007 SHALL have port inputData, input, 128 bits: ciphertext.
REQ-008 SHALL have port outputData, output, 128 bits: recovered plaintext, registered.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion strobe.

Function
REQ-011 SHALL use the FIPS-197 byte order: bits [127:120] = byte 0; the state is column-major.
REQ-012 SHALL derive round keys rk0..rk10 from the latched key through the team's combinational key schedule (1408-bit array, rk0 = key).
REQ-013 SHALL implement the FSM states IDLE, ROUND and FINAL, one transform step per clock.
REQ-014 IDLE, on an edge with decryptEnable=1, SHALL latch key, load state <= inputData ^ rk10, set round counter = 9, set busy=1, and go to ROUND.
REQ-015 ROUND, each edge, SHALL compute state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[counter]).
REQ-016 In ROUND, the counter SHALL decrement by one per edge; after the counter=1 step the FSM SHALL go to FINAL.
REQ-017 FINAL SHALL compute outputData <= InvSubBytes(InvShiftRows(state)) ^ rk0, set done=1, set busy=0, and go to IDLE.
REQ-018 Latency: the accept edge is E. Rounds 9..1 occur at E+1..E+9 and FINAL at E+10. done is high exactly for the cycle between E+10 and E+11.
REQ-019 busy SHALL be high from edge E up to edge E+10; it SHALL be low in IDLE.
REQ-020 decryptEnable SHALL be ignored while busy=1; there is no queueing.
REQ-021 A request present in the cycle where done=1 SHALL be accepted at the next edge (back-to-back throughput of one block per 11 cycles).
REQ-022 Changes to key or inputData after the accept edge SHALL NOT affect the running operation.
REQ-023 outputData SHALL hold its last result until the next FINAL; it SHALL NOT change during ROUND.
REQ-024 InvSubBytes SHALL use the FIPS-197 inverse S-box.
REQ-025 InvMixColumns SHALL use GF(2^8) multiplication by 0e, 0b, 0d and 09 with modulus x^8+x^4+x^3+x+1.
REQ-026 The round counter SHALL be 4 bits and SHALL never wrap below 0.

Reset
REQ-027 While rst=1, the block SHALL force state=IDLE, outputData=0, busy=0, done=0, counter=0 and internal state register=0, asynchronously.
REQ-028 rst asserted mid-operation SHALL abort the operation; no done SHALL follow, and the block SHALL accept a new request on the first edge after rst deasserts.

Verification
REQ-029 SHALL cover the FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, inputData 69c4e0d86a7b0430d8cdb78070b4c55a -> outputData 00112233445566778899aabbccddeeff with done exactly 10 edges after accept.
REQ-030 SHALL cover the FIPS-197 B vector: key 2b7e151628aed2a6abf7158809cf4f3c, inputData 3925841d02dc09fbdc118597196a0b32 -> outputData 3243f6a8885a308d313198a2e0370734.
REQ-031 SHALL cover the back-to-back case: decryptEnable held high with C.1 then B inputs -> two done pulses 11 cycles apart, both results correct.
REQ-032 SHALL cover input changes mid-operation: key and inputData randomized at E+3 -> C.1 result unchanged; decryptEnable pulses during busy are ignored.
REQ-033 SHALL cover reset mid-operation: rst pulsed at E+5 -> outputs 0 immediately, no done; a following C.1 run is correct.
REQ-034 SHALL cover the round trip: random key/plaintext encrypted with the team's encryption block and then decrypted -> original plaintext over 1000 iterations.

Source files
------------

// File: rtl/decryption_block_if.sv
// Handshake and data bus of the AES-128 decryption block.
// The requester drives the master side and the block implements the slave side.
interface decryption_block_if;
  logic         decryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
  logic         busy;
  logic         done;

  modport master (
    output decryptEnable, key, inputData,
    input  outputData, busy, done
  );

  modport slave (
    input  decryptEnable, key, inputData,
    output outputData, busy, done
  );
endinterface

// File: rtl/decryption_block.sv
// Iterative AES-128 inverse cipher: one transform step per clock, 11 cycles per block.
// state  | meaning
// IDLE   | waiting for decryptEnable; initial AddRoundKey(rk10) on accept
// ROUND  | inverse rounds 9..1, one per clock
// FINAL  | last inverse round without InvMixColumns, output register and done strobe
module decryption_block #(
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  decryption_block_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte, so entry b starts at bit (255-b)*8 = {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

  // Round key i occupies rk[128*i +: 128]; rk0 is the cipher key itself.
  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] rk;
    rcon = 8'h01;
    rk   = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if ((i % 4) == 0) begin
        t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 11; i++)
      rk[128*i +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return rk;
  endfunction

  logic [1:0]    fsm_q, fsm_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [127:0]  ks_key;
  logic [1407:0] rk_all;
  logic [127:0]  rk_round;
  logic [127:0]  rk_last;
  logic [127:0]  shift_sub;

  // In IDLE the schedule runs off the incoming key so rk10 is ready on the accept edge.
  assign ks_key    = (fsm_q == S_IDLE) ? bus.key : key_q;
  assign rk_all    = expand_key(ks_key);
  assign rk_round  = rk_all[{cnt_q, 7'b0} +: 128];
  assign rk_last   = rk_all[128*NUM_ROUNDS +: 128];
  assign shift_sub = inv_sub_bytes(inv_shift_rows(st_q));

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    st_d   = st_q;
    out_d  = out_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (bus.decryptEnable) begin
          key_d  = bus.key;
          st_d   = bus.inputData ^ rk_last;
          cnt_d  = LAST_ROUND;
          busy_d = 1'b1;
          fsm_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d = inv_mix_columns(shift_sub ^ rk_round);
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        out_d  = shift_sub ^ rk_all[127:0];
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= 4'd0;
      key_q  <= '0;
      st_q   <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      st_q   <= st_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.outputData = out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_decryption_block.sv
// Directed bench for decryption_block: FIPS-197 vectors, timing, abort and a
// round trip against a small forward AES-128 model.
module tb_decryption_block;

  logic clk;
  logic rst;
  decryption_block_if bus ();

  decryption_block #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_tbl[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward AES-128 used to produce ciphertext for the round-trip test.
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if ((i % 4) == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) s[127 - 8*n -: 8] = sb(s[127 - 8*n -: 8]);
      o = '0;
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          o[127 - 8*(rr + 4*c) -: 8] = s[127 - 8*(rr + 4*((c + rr) & 3)) -: 8];
      s = o;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127 - 32*c -: 8];
          a1 = s[119 - 32*c -: 8];
          a2 = s[111 - 32*c -: 8];
          a3 = s[103 - 32*c -: 8];
          s[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request; returns #1 after the accept edge with decryptEnable dropped.
  task automatic start(input logic [127:0] k, input logic [127:0] d);
    bus.key           = k;
    bus.inputData     = d;
    bus.decryptEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.decryptEnable = 1'b0;
  endtask

  // Counts edges until done; lat = 0 if it never comes within the budget.
  task automatic wait_done(output int lat, output int busy_bad, output int out_moved);
    logic [127:0] out0;
    out0      = bus.outputData;
    lat       = 0;
    busy_bad  = 0;
    out_moved = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_bad++;
      if (bus.outputData !== out0) out_moved++;
    end
  endtask

  task automatic run_vector(input string tag, input logic [127:0] k, input logic [127:0] ct,
                            input logic [127:0] pt);
    int lat, busy_bad, out_moved;
    start(k, ct);
    check({tag, "_busy_at_accept"}, bus.busy, 1);
    wait_done(lat, busy_bad, out_moved);
    check({tag, "_latency"}, lat, 10);
    check({tag, "_data"}, bus.outputData, pt);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_out_stable"}, out_moved, 0);
  endtask

  initial begin
    int lat, busy_bad, out_moved, dones;
    logic [127:0] rk, rp, rc;

    rst               = 1'b1;
    bus.decryptEnable = 1'b0;
    bus.key           = '0;
    bus.inputData     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", bus.outputData, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_vector("c1", C1_KEY, C1_CT, C1_PT);
    @(posedge clk);
    #1;
    check("c1_done_one_cycle", bus.done, 0);

    run_vector("b", B_KEY, B_CT, B_PT);
    @(posedge clk);
    #1;

    // Back-to-back: enable stays high; B is presented while C.1 is running.
    bus.key           = C1_KEY;
    bus.inputData     = C1_CT;
    bus.decryptEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.key       = B_KEY;
    bus.inputData = B_CT;
    wait_done(lat, busy_bad, out_moved);
    check("b2b_first_latency", lat, 10);
    check("b2b_first_data", bus.outputData, C1_PT);
    wait_done(lat, busy_bad, out_moved);
    bus.decryptEnable = 1'b0;
    check("b2b_gap", lat, 11);
    check("b2b_second_data", bus.outputData, B_PT);
    check("b2b_second_busy", busy_bad, 0);
    @(posedge clk);
    #1;

    // Inputs scrambled and a stray enable pulse at E+3.
    start(C1_KEY, C1_CT);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.key           = {$urandom, $urandom, $urandom, $urandom};
    bus.inputData     = {$urandom, $urandom, $urandom, $urandom};
    bus.decryptEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.decryptEnable = 1'b0;
    bus.key           = {$urandom, $urandom, $urandom, $urandom};
    bus.inputData     = {$urandom, $urandom, $urandom, $urandom};
    wait_done(lat, busy_bad, out_moved);
    check("midop_latency", lat, 7);
    check("midop_data", bus.outputData, C1_PT);
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    check("midop_no_queued_run", dones, 0);

    // Abort with rst held across E+5, then a fresh C.1 run right after release.
    start(B_KEY, B_CT);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("abort_out", bus.outputData, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vector("post_abort", C1_KEY, C1_CT, C1_PT);
    @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = aes_enc(rk, rp);
      start(rk, rc);
      wait_done(lat, busy_bad, out_moved);
      check("round_trip", bus.outputData, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
